// File: rtl/btn_event_gen.sv
// Button event generator: press, release, long-press and auto-repeat pulses from a debounced level.
// Auto-repeat is built only when BTN_EVENT_REPEAT_EN is defined.
module btn_event_gen #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("btn_event_gen: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          held_q, held_d;

`ifdef BTN_EVENT_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_q, rep_d;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    long_d     = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (btn_level) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end
      end
      PRESSED: begin
        // Release is tested first so it beats a coincident hold expiry.
        if (!btn_level) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rel_d      = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = LONG;
          long_d     = 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
          rep_cnt_d  = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rel_d      = 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
          rep_cnt_d  = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d  = '0;
          rep_d      = 1'b1;
        end else begin
          rep_cnt_d  = rep_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
      rep_cnt_q  <= '0;
      rep_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
      held_q     <= held_d;
`ifdef BTN_EVENT_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      rep_q      <= rep_d;
`endif
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;
  assign held          = held_q;
`ifdef BTN_EVENT_REPEAT_EN
  assign repeat_pulse  = rep_q;
`else
  assign repeat_pulse  = 1'b0;
`endif
endmodule

// File: tb/tb_btn_event_gen.sv
// Randomized + directed bench for btn_event_gen against a run-length based reference model.
module tb_btn_event_gen;
  localparam int H = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_level = 1'b0;
  logic press_pulse, release_pulse, long_press, repeat_pulse, held;

  btn_event_gen #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press(long_press), .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;

  // Model: k = number of high samples since the press edge (press edge is k=0).
  bit m_active;
  int m_k;
  bit e_press, e_rel, e_long, e_rep;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_k <= 0;
      e_press <= 1'b0; e_rel <= 1'b0; e_long <= 1'b0; e_rep <= 1'b0;
    end else begin
      e_press <= 1'b0; e_rel <= 1'b0; e_long <= 1'b0; e_rep <= 1'b0;
      if (!m_active) begin
        if (btn_level) begin m_active <= 1'b1; m_k <= 0; e_press <= 1'b1; end
      end else if (!btn_level) begin
        m_active <= 1'b0; e_rel <= 1'b1;
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == H) e_long <= 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
        if (m_k + 1 > H && ((m_k + 1 - H) % R) == 0) e_rep <= 1'b1;
`endif
      end
    end
  end

  int n_cmp = 0, n_err = 0;
  int c_press, c_rel, c_long, c_rep, c_held, idx, long_idx, rel_idx, rep_first, rep_last;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    c_press = 0; c_rel = 0; c_long = 0; c_rep = 0; c_held = 0;
    idx = 0; long_idx = -1; rel_idx = -1; rep_first = -1; rep_last = -1;
  endtask

  task automatic drive(input bit b);
    @(negedge clk); #1 btn_level = b;
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) drive(b);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk); #1 reset = 1'b1;
    repeat (n) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    clr();
    fork
      forever begin
        @(negedge clk);
        chk("press_pulse", press_pulse, e_press);
        chk("release_pulse", release_pulse, e_rel);
        chk("long_press", long_press, e_long);
        chk("repeat_pulse", repeat_pulse, e_rep);
        chk("held", held, m_active);
        chk("onehot_pulses", int'(press_pulse) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse) <= 1, 1);
        idx++;
        if (press_pulse) begin c_press++; idx = 0; end
        if (release_pulse) begin c_rel++; rel_idx = idx; end
        if (long_press) begin c_long++; long_idx = idx; end
        if (repeat_pulse) begin c_rep++; if (rep_first < 0) rep_first = idx; rep_last = idx; end
        if (held) c_held++;
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_held", held, 0);
    chk("reset_press", press_pulse, 0);
    #1 reset = 1'b0;
    run(0, 3);

    // short press
    clr(); run(1, 3); run(0, 3);
    chk("short_press_cnt", c_press, 1);
    chk("short_rel_cnt", c_rel, 1);
    chk("short_long_cnt", c_long, 0);
    chk("short_held_cycles", c_held, 3);

    // 20-cycle hold
    clr(); run(1, 20); run(0, 3);
    chk("hold20_long_idx", long_idx, 8);
    chk("hold20_rel_idx", rel_idx, 20);
`ifdef BTN_EVENT_REPEAT_EN
    chk("hold20_rep_cnt", c_rep, 2);
    chk("hold20_rep_first", rep_first, 12);
    chk("hold20_rep_last", rep_last, 16);
`else
    chk("hold20_rep_cnt", c_rep, 0);
`endif

    // release on the hold-expiry edge
    clr(); run(1, 8); run(0, 3);
    chk("e8low_long_cnt", c_long, 0);
    chk("e8low_rel_cnt", c_rel, 1);
    chk("e8low_rel_idx", rel_idx, 8);

    // reset mid-hold with button still high
    clr(); run(1, 5); pulse_reset(2); run(1, 2); run(0, 3);
    chk("rst_press_cnt", c_press, 2);
    chk("rst_rel_cnt", c_rel, 1);

    // 1-0-1 pattern
    clr(); drive(1); drive(0); drive(1); run(0, 3);
    chk("101_press_cnt", c_press, 2);
    chk("101_rel_cnt", c_rel, 2);

    // random runs with occasional reset
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 2));
      run(1'($urandom_range(0, 1)), $urandom_range(1, 30));
    end
    run(0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/btn_event_gen.md
BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000; clock cycles btn_level must stay high after the press edge before long_press fires. Legal range is >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 10000000; clock cycles between auto-repeat pulses. Legal range is >= 2.
REQ-003 clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_level  input  1  debounced button level, synchronous to clk.
REQ-006 press_pulse  output  1  one-cycle pulse on a press.
REQ-007 release_pulse  output  1  one-cycle pulse on a release.
REQ-008 long_press  output  1  one-cycle pulse when the hold threshold is reached.
REQ-009 repeat_pulse  output  1  one-cycle auto-repeat pulse while the button is held long.
REQ-010 held  output  1  level; high while the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have three states: IDLE, PRESSED and LONG.
REQ-012 In IDLE, an edge sampling btn_level=1 (call it E0) SHALL move the FSM to PRESSED, clear hold_cnt and assert press_pulse for the one cycle after E0.
REQ-013 In PRESSED, each edge sampling btn_level=1 SHALL increment hold_cnt; at edge E0+HOLD_CYCLES the FSM SHALL move to LONG, assert long_press for one cycle and clear rep_cnt.
REQ-014 In LONG, each edge sampling btn_level=1 SHALL increment rep_cnt; every REPEAT_CYCLES edges (E0+HOLD_CYCLES+k*REPEAT_CYCLES, k>=1) repeat_pulse SHALL assert for one cycle and rep_cnt SHALL return to 0.
REQ-015 In PRESSED or LONG, an edge sampling btn_level=0 SHALL move the FSM to IDLE, assert release_pulse for one cycle and clear both counters.
REQ-016 If release coincides with a hold or repeat expiry edge, release SHALL win: no long_press or repeat_pulse fires on that edge.
REQ-017 All outputs SHALL be registered, with exactly one clock of latency from the sampling edge.
REQ-018 At most one of press_pulse, release_pulse, long_press and repeat_pulse SHALL be high in any cycle.
REQ-019 Counter widths SHALL be $clog2 of the matching parameter plus 1; counters never wrap inside a state.
REQ-020 A press immediately after a release (btn_level 1-0-1 on consecutive edges) SHALL give release_pulse then press_pulse on consecutive cycles.
REQ-021 btn_level held high out of reset SHALL be treated as a new press on the first edge after reset deasserts.

Reset
REQ-022 While reset is high, the FSM SHALL be in IDLE, both counters SHALL be 0, and all five outputs SHALL be 0, asynchronously.
REQ-023 Reset asserted mid-hold SHALL suppress release_pulse; operation after reset follows REQ-021.

Configuration
REQ-024 The macro BTN_EVENT_REPEAT_EN SHALL control auto-repeat.
  - Defined: REQ-014 behaviour applies.
  - Undefined: repeat_pulse is tied to 0, rep_cnt is not built, and LONG waits only for release.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4, BTN_EVENT_REPEAT_EN defined unless noted)
REQ-025 Button high 3 cycles then low -> press_pulse after E0, release_pulse after E3, no long_press, held high for exactly 3 cycles.
REQ-026 Button high 20 cycles -> press at E0, long_press at E8, repeat_pulse at E12 and E16, release_pulse after E20.
REQ-027 Button low on edge E8 -> release_pulse only, long_press stays 0.
REQ-028 Reset pulsed at E5 of a hold with btn_level still high -> outputs 0 during reset, no release_pulse, press_pulse on the first edge after reset deasserts.
REQ-029 BTN_EVENT_REPEAT_EN undefined, button high 20 cycles -> long_press at E8, repeat_pulse never asserts.
REQ-030 Pattern 1,0,1 on consecutive edges -> press_pulse, release_pulse, press_pulse on consecutive cycles, with no cycle having two pulses high.
